sysbus_mem_responder: RTL and testbench



---
 rtl/sysbus_mem_responder_if.sv | 23 ++
 rtl/sysbus_mem_responder.sv | 143 ++++++++++++++
 tb/tb_sysbus_mem_responder.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/sysbus_mem_responder_if.sv
// Sysbus request/response bundle between a requester (master) and a memory responder (slave).
interface sysbus_mem_responder_if #(
    parameter int TAG_W = 13
);
    logic             reqcyc;
    logic [63:0]      req;
    logic [TAG_W-1:0] reqtag;
    logic             reqack;
    logic             respcyc;
    logic [63:0]      resp;
    logic [TAG_W-1:0] resptag;
    logic             respack;

    modport master (
        output reqcyc, req, reqtag, respack,
        input  reqack, respcyc, resp, resptag
    );

    modport slave (
        input  reqcyc, req, reqtag, respack,
        output reqack, respcyc, resp, resptag
    );
endinterface

// File: rtl/sysbus_mem_responder.sv
// Sysbus line responder: 8-beat line writes into a word array, 8-beat read bursts after LATENCY cycles.
// Optional macro CRITICAL_WORD_FIRST_EN: read bursts start at the requested word and wrap within the line.
module sysbus_mem_responder #(
    parameter int MEM_WORDS = 8192,
    parameter int LATENCY   = 4,
    parameter int TAG_W     = 13
) (
    input  logic                   clk,
    input  logic                   reset,
    sysbus_mem_responder_if.slave  bus
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam int LW = AW - 3;
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WDATA, S_WAIT, S_RESP} state_t;

    state_t           r_state;
    logic [LW-1:0]    r_line;
    logic [2:0]       r_beat;
    logic [CW-1:0]    r_lat;
    logic [TAG_W-1:0] r_tag;
    logic [63:0]      r_resp;
    logic             r_respcyc;
    logic [TAG_W-1:0] r_resptag;
    logic [63:0]      r_mem [MEM_WORDS];

    logic             w_xfer;
    logic             w_hdr;
    logic             w_hdr_rd;
    logic             w_wr;
    logic [LW-1:0]    w_rd_line;
    logic [2:0]       w_rd_beat;
    logic [2:0]       w_rd_word;
    logic [63:0]      w_rd_data;

    // Only the header/write-data states listen; the gate on reset keeps reqack low asynchronously.
    assign w_xfer   = !reset && bus.reqcyc && (r_state == S_IDLE || r_state == S_WDATA);
    assign w_hdr    = w_xfer && (r_state == S_IDLE);
    assign w_hdr_rd = w_hdr && bus.reqtag[TAG_W-1];
    assign w_wr     = w_xfer && (r_state == S_WDATA);

    assign bus.reqack  = w_xfer;
    assign bus.respcyc = r_respcyc;
    assign bus.resp    = r_resp;
    assign bus.resptag = r_resptag;

    // Address of the beat to load into r_resp on this edge: beat 0 when entering RESP, else the next beat.
    always_comb begin
        w_rd_line = r_line;
        w_rd_beat = 3'd0;
        if (r_state == S_IDLE)
            w_rd_line = bus.req[6 +: LW];
        if (r_state == S_RESP)
            w_rd_beat = r_beat + 3'd1;
    end

`ifdef CRITICAL_WORD_FIRST_EN
    logic [2:0] r_off;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_off <= 3'd0;
        else if (w_hdr)
            r_off <= bus.req[5:3];
    end

    assign w_rd_word = w_rd_beat + ((r_state == S_IDLE) ? bus.req[5:3] : r_off);
`else
    assign w_rd_word = w_rd_beat;
`endif

    assign w_rd_data = r_mem[{w_rd_line, w_rd_word}];

    always_ff @(posedge clk) begin
        if (w_wr)
            r_mem[{r_line, r_beat}] <= bus.req;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_line    <= '0;
            r_beat    <= 3'd0;
            r_lat     <= '0;
            r_tag     <= '0;
            r_resp    <= 64'd0;
            r_respcyc <= 1'b0;
            r_resptag <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_hdr) begin
                        r_line <= bus.req[6 +: LW];
                        r_tag  <= bus.reqtag;
                        r_beat <= 3'd0;
                        r_lat  <= '0;
                        if (!w_hdr_rd) begin
                            r_state <= S_WDATA;
                        end else if (LATENCY == 0) begin
                            r_state   <= S_RESP;
                            r_respcyc <= 1'b1;
                            r_resp    <= w_rd_data;
                            r_resptag <= bus.reqtag;
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WDATA: begin
                    if (w_xfer) begin
                        r_beat <= r_beat + 3'd1;
                        if (r_beat == 3'd7)
                            r_state <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (r_lat == CW'(LATENCY - 1)) begin
                        r_state   <= S_RESP;
                        r_respcyc <= 1'b1;
                        r_resp    <= w_rd_data;
                        r_resptag <= r_tag;
                    end else begin
                        r_lat <= r_lat + 1'b1;
                    end
                end
                S_RESP: begin
                    if (bus.respack) begin
                        if (r_beat == 3'd7) begin
                            r_respcyc <= 1'b0;
                            r_beat    <= 3'd0;
                            r_state   <= S_IDLE;
                        end else begin
                            r_beat <= r_beat + 3'd1;
                            r_resp <= w_rd_data;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sysbus_mem_responder.sv
// Bench for sysbus_mem_responder: directed protocol checks plus randomized line traffic against a word-array model.
module tb_sysbus_mem_responder;
    localparam int MEM_WORDS = 8192;
    localparam int LATENCY   = 4;
    localparam int TAG_W     = 13;
    localparam logic [63:0] LINE_MASK = 64'((MEM_WORDS * 8) - 1) & ~64'd63;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;

    logic [63:0] mdl [int];
    logic [63:0] wbuf [8];
    logic [63:0] ebuf [8];

    sysbus_mem_responder_if #(.TAG_W(TAG_W)) bus();

    sysbus_mem_responder #(.MEM_WORDS(MEM_WORDS), .LATENCY(LATENCY), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int widx(input logic [63:0] a);
        return int'((a >> 3) & 64'(MEM_WORDS - 1));
    endfunction

    // Expected read burst: the 8 words of the addressed line, rotated to the requested word when enabled.
    task automatic build_exp(input logic [63:0] a);
        int w, line, off;
        w = widx(a);
        line = w & ~7;
`ifdef CRITICAL_WORD_FIRST_EN
        off = w & 7;
`else
        off = 0;
`endif
        for (int b = 0; b < 8; b++) ebuf[b] = mdl[line + ((off + b) & 7)];
    endtask

    // All tasks start and end just after a falling edge.
    task automatic wr_line(input logic [63:0] addr, input logic [TAG_W-1:0] tag, input bit gaps);
        int base;
        base = widx(addr) & ~7;
        bus.reqcyc = 1'b1; bus.req = addr; bus.reqtag = tag;
        #1 chk("wr_hdr_ack", 64'(bus.reqack), 64'd1);
        @(posedge clk);
        for (int b = 0; b < 8; b++) begin
            @(negedge clk);
            if (gaps && $urandom_range(0, 2) == 0) begin
                bus.reqcyc = 1'b0; bus.req = {$urandom, $urandom};
                #1 chk("wr_gap_ack", 64'(bus.reqack), 64'd0);
                @(posedge clk);
                @(negedge clk);
            end
            bus.reqcyc = 1'b1; bus.req = wbuf[b];
            #1 chk("wr_dat_ack", 64'(bus.reqack), 64'd1);
            @(posedge clk);
            mdl[base + b] = wbuf[b];
        end
        @(negedge clk);
        bus.reqcyc = 1'b0;
        #1;
    endtask

    task automatic send_hdr(input logic [63:0] addr, input logic [TAG_W-1:0] tag);
        bus.reqcyc = 1'b1; bus.req = addr; bus.reqtag = tag;
        #1 chk("rd_hdr_ack", 64'(bus.reqack), 64'd1);
        @(posedge clk);
        @(negedge clk);
        bus.reqcyc = 1'b0; bus.req = {$urandom, $urandom};
    endtask

    // Called at the first falling edge after the header edge; counts cycles to the first beat.
    task automatic wait_resp();
        int n;
        n = 1;
        #1;
        while (bus.respcyc !== 1'b1 && n <= 3 * LATENCY + 10) begin
            chk("wait_busy_ack", 64'(bus.reqack), 64'd0);
            @(negedge clk); #1;
            n++;
        end
        chk("rsp_latency", 64'(n), 64'(LATENCY + 1));
    endtask

    task automatic beats(input logic [TAG_W-1:0] tag, input int stall_beat, input int stall_len,
                         input bit rnd, input int max_acks, input int exp_cycles);
        int b, cyc, st;
        bit ack;
        b = 0; cyc = 0; st = 0;
        while (b < max_acks && cyc < 200) begin
            chk("rsp_cyc", 64'(bus.respcyc), 64'd1);
            chk("rsp_data", bus.resp, ebuf[b]);
            chk("rsp_tag", 64'(bus.resptag), 64'(tag));
            chk("rsp_busy_ack", 64'(bus.reqack), 64'd0);
            ack = 1'b1;
            if (b == stall_beat && st < stall_len) begin
                ack = 1'b0; st++;
            end else if (rnd && $urandom_range(0, 3) == 0) begin
                ack = 1'b0;
            end
            bus.respack = ack;
            @(posedge clk);
            if (ack) b++;
            cyc++;
            @(negedge clk); #1;
        end
        bus.respack = 1'b0;
        if (exp_cycles > 0) chk("rsp_cycles", 64'(cyc), 64'(exp_cycles));
        if (max_acks == 8) chk("rsp_end", 64'(bus.respcyc), 64'd0);
    endtask

    initial begin
        logic [63:0] a, a2;
        bus.reqcyc = 1'b0; bus.req = 64'd0; bus.reqtag = '0; bus.respack = 1'b0;

        // reset state, held and after release
        repeat (3) begin
            @(negedge clk); #1;
            chk("rst_reqack", 64'(bus.reqack), 64'd0);
            chk("rst_respcyc", 64'(bus.respcyc), 64'd0);
            chk("rst_resp", bus.resp, 64'd0);
            chk("rst_resptag", 64'(bus.resptag), 64'd0);
        end
        @(negedge clk); reset = 1'b0;
        repeat (3) begin
            @(negedge clk); #1;
            chk("idle_reqack", 64'(bus.reqack), 64'd0);
            chk("idle_respcyc", 64'(bus.respcyc), 64'd0);
            chk("idle_resp", bus.resp, 64'd0);
        end

        // line write then read back at 0x80
        for (int i = 0; i < 8; i++) wbuf[i] = 64'h1000 + 64'(i);
        wr_line(64'h80, 13'h0105, 1'b0);
        send_hdr(64'h80, 13'h1107);
        build_exp(64'h80);
        wait_resp();
        beats(13'h1107, -1, 0, 1'b0, 8, 8);

        // respack stall on beat 3 for 4 cycles
        send_hdr(64'h80, 13'h1107);
        build_exp(64'h80);
        wait_resp();
        beats(13'h1107, 3, 4, 1'b0, 8, 12);

        // mid-line address
        send_hdr(64'h98, 13'h1198);
        build_exp(64'h98);
        wait_resp();
        beats(13'h1198, -1, 0, 1'b0, 8, 8);

        // next header held during the busy burst
        send_hdr(64'h80, 13'h1101);
        build_exp(64'h80);
        bus.reqcyc = 1'b1; bus.req = 64'h98; bus.reqtag = 13'h1102;
        wait_resp();
        beats(13'h1101, -1, 0, 1'b1, 8, 0);
        chk("held_hdr_ack", 64'(bus.reqack), 64'd1);
        build_exp(64'h98);
        send_hdr(64'h98, 13'h1102);
        wait_resp();
        beats(13'h1102, -1, 0, 1'b0, 8, 8);

        // asynchronous reset after beat 2 is acked
        send_hdr(64'h80, 13'h1103);
        build_exp(64'h80);
        wait_resp();
        beats(13'h1103, -1, 0, 1'b0, 3, 0);
        chk("pre_rst_respcyc", 64'(bus.respcyc), 64'd1);
        bus.reqcyc = 1'b1; bus.req = 64'h80; bus.reqtag = 13'h1104;
        #2 reset = 1'b1;
        #1;
        chk("arst_respcyc", 64'(bus.respcyc), 64'd0);
        chk("arst_resp", bus.resp, 64'd0);
        chk("arst_resptag", 64'(bus.resptag), 64'd0);
        chk("arst_reqack", 64'(bus.reqack), 64'd0);
        repeat (2) begin
            @(negedge clk); #1;
            chk("rst_held_reqack", 64'(bus.reqack), 64'd0);
        end
        @(negedge clk);
        bus.reqcyc = 1'b0; reset = 1'b0;
        @(negedge clk);
        send_hdr(64'h80, 13'h1105);
        build_exp(64'h80);
        wait_resp();
        beats(13'h1105, -1, 0, 1'b0, 8, 8);

        // random lines: aliased addresses, gapped writes, random offsets and stalls
        for (int it = 0; it < 10; it++) begin
            a = {$urandom, $urandom};
            for (int i = 0; i < 8; i++) wbuf[i] = {$urandom, $urandom};
            wr_line(a, {1'b0, 12'($urandom)}, 1'b1);
            a2 = {$urandom, $urandom};
            a2 = (a2 & ~LINE_MASK) | (a & LINE_MASK);
            build_exp(a2);
            send_hdr(a2, 13'h1000 | 13'(it));
            wait_resp();
            beats(13'h1000 | 13'(it), -1, 0, 1'b1, 8, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
